// File: rtl/gpio_lsb_merge_pkg.sv
// Shared constants, register field positions and types for the gpio LSB merge block.
package gpio_lsb_merge_pkg;

  localparam logic [6:0] FR_RX_GPIO_MERGE = 7'd49;

  localparam int CH0_EN_BIT = 0;
  localparam int CH1_EN_BIT = 1;
  localparam int IONLY_BIT  = 2;
  localparam int DELAY_LSB  = 8;

  localparam int NUM_LANES  = 4;
  localparam int SAMPLE_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Lane order everywhere is {ch1_q, ch1_i, ch0_q, ch0_i}.
  function automatic logic [SAMPLE_W-1:0] merge_lsb(input logic [SAMPLE_W-1:0] s,
                                                   input logic en,
                                                   input logic run,
                                                   input logic b);
    if (!en) return s;
    return {s[SAMPLE_W-1:1], run & b};
  endfunction

endpackage

// File: rtl/gpio_lsb_merge_delay.sv
// Circular buffer of gpio bit groups; reads sit 'offset' entries behind the newest write.
module gpio_bit_delay_line #(
  parameter int LOG_DEPTH = 4,
  parameter int W         = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr_i,
  input  logic                 wr_en_i,
  input  logic [W-1:0]         wr_data_i,
  input  logic [LOG_DEPTH-1:0] offset_i,
  output logic [W-1:0]         rd_data_o
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [W-1:0]         mem_q [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr_q;
  logic [LOG_DEPTH-1:0] rd_addr;

  // Uses the pre-write pointer, so a same-cycle write is never seen by the read.
  assign rd_addr   = wr_ptr_q - LOG_DEPTH'(1) - offset_i;
  assign rd_data_o = mem_q[rd_addr];

  always_ff @(posedge clock) begin
    if (reset || clr_i) wr_ptr_q <= '0;
    else if (wr_en_i)   wr_ptr_q <= wr_ptr_q + LOG_DEPTH'(1);
  end

  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/gpio_lsb_merge_setting_reg.sv
// Setting-bus register: captures the low WIDTH bits of the bus data on a write to ADDR.
module setting_reg #(
  parameter logic [6:0] ADDR  = 7'd0,
  parameter int         WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             strobe_i,
  input  logic [6:0]       addr_i,
  input  logic [31:0]      data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic             unused_hi;

  assign unused_hi = ^data_i[31:WIDTH];
  assign data_o    = data_q;

  always_ff @(posedge clock) begin
    if (reset)                          data_q <= '0;
    else if (strobe_i && addr_i == ADDR) data_q <= data_i[WIDTH-1:0];
  end

endmodule

// File: rtl/gpio_lsb_merge.sv
// Replaces DDC sample LSBs with delayed gpio bits; FSM gates merging until the line is primed.
module gpio_lsb_merge
  import gpio_lsb_merge_pkg::*;
#(
  parameter logic [6:0] SR_ADDR   = FR_RX_GPIO_MERGE,
  parameter int         LOG_DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic [6:0]    serial_addr,
  input  logic [31:0]   serial_data,
  input  logic          serial_strobe,
  input  logic          dig_strobe,
  input  logic          rx_dig0_i,
  input  logic          rx_dig0_q,
  input  logic          rx_dig1_i,
  input  logic          rx_dig1_q,
  input  logic          rx_strobe,
  input  logic [15:0]   ch0_i,
  input  logic [15:0]   ch0_q,
  input  logic [15:0]   ch1_i,
  input  logic [15:0]   ch1_q,
  output logic          out_strobe,
  output logic [15:0]   out0_i,
  output logic [15:0]   out0_q,
  output logic [15:0]   out1_i,
  output logic [15:0]   out1_q,
  output logic          misalign
);

  localparam int SRW = DELAY_LSB + LOG_DEPTH;

  logic [SRW-1:0]       sr_q;
  logic                 unused_sr;
  logic                 sr_wr;
  logic [LOG_DEPTH-1:0] delay;
  logic [LOG_DEPTH:0]   target;

  setting_reg #(.ADDR(SR_ADDR), .WIDTH(SRW)) u_sr (
    .clock    (clock),
    .reset    (reset),
    .strobe_i (serial_strobe),
    .addr_i   (serial_addr),
    .data_i   (serial_data),
    .data_o   (sr_q)
  );

  assign unused_sr = ^sr_q[DELAY_LSB-1:IONLY_BIT+1];
  assign sr_wr     = serial_strobe && (serial_addr == SR_ADDR);
  assign delay     = sr_q[DELAY_LSB +: LOG_DEPTH];
  assign target    = {1'b0, delay} + (LOG_DEPTH+1)'(1);

  state_t             state_q, state_d;
  logic [LOG_DEPTH:0] fill_q, fill_d;
  logic               dig_valid_q;
  logic               active, run;
  logic [NUM_LANES-1:0] rd_bits;

  assign active = (state_q != ST_IDLE);
  assign run    = (state_q == ST_RUN);

  always_ff @(posedge clock) begin
    if (reset) dig_valid_q <= 1'b0;
    else       dig_valid_q <= dig_strobe;
  end

  gpio_bit_delay_line #(.LOG_DEPTH(LOG_DEPTH), .W(NUM_LANES)) u_line (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (!active),
    .wr_en_i   (dig_valid_q && active),
    .wr_data_i ({rx_dig1_q, rx_dig1_i, rx_dig0_q, rx_dig0_i}),
    .offset_i  (delay),
    .rd_data_o (rd_bits)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      ST_IDLE: begin
        fill_d = '0;
        if (enable) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (dig_valid_q && fill_q != target) fill_d = fill_q + (LOG_DEPTH+1)'(1);
        if (fill_d == target) state_d = ST_RUN;
      end
      ST_RUN:  ;
      default: state_d = ST_IDLE;
    endcase
    // Register writes restart priming without losing the buffered bits.
    if (sr_wr) begin
      state_d = ST_PRIME;
      fill_d  = '0;
    end
    if (!enable) begin
      state_d = ST_IDLE;
      fill_d  = '0;
    end
  end

  // dig_pend/rx_pend: that event has occurred since the last one of the other kind.
  logic dig_pend_q, rx_pend_q, misalign_q;
  logic err;

  assign err = (dig_valid_q && !rx_strobe && dig_pend_q) ||
               (rx_strobe && !dig_valid_q && rx_pend_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      misalign_q <= 1'b0;
      dig_pend_q <= 1'b0;
      rx_pend_q  <= 1'b0;
    end else if (sr_wr) begin
      misalign_q <= 1'b0;
      dig_pend_q <= 1'b0;
      rx_pend_q  <= 1'b0;
    end else if (!active) begin
      dig_pend_q <= 1'b0;
      rx_pend_q  <= 1'b0;
    end else begin
      if (run && err) misalign_q <= 1'b1;
      if (dig_valid_q || rx_strobe) begin
        dig_pend_q <= dig_valid_q && !rx_strobe;
        rx_pend_q  <= rx_strobe && !dig_valid_q;
      end
    end
  end

  logic [NUM_LANES-1:0][SAMPLE_W-1:0] ch_in, merged_d, out_q;
  logic [NUM_LANES-1:0]               lane_en;
  logic                               out_strobe_q;

  assign ch_in   = {ch1_q, ch1_i, ch0_q, ch0_i};
  assign lane_en = {NUM_LANES{active}} &
                   {sr_q[CH1_EN_BIT] & ~sr_q[IONLY_BIT], sr_q[CH1_EN_BIT],
                    sr_q[CH0_EN_BIT] & ~sr_q[IONLY_BIT], sr_q[CH0_EN_BIT]};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    assign merged_d[l] = merge_lsb(ch_in[l], lane_en[l], run, rd_bits[l]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_strobe_q <= 1'b0;
      out_q        <= '0;
    end else begin
      out_strobe_q <= rx_strobe && enable;
      if (rx_strobe) out_q <= merged_d;
    end
  end

  assign out_strobe = out_strobe_q;
  assign out0_i     = out_q[0];
  assign out0_q     = out_q[1];
  assign out1_i     = out_q[2];
  assign out1_q     = out_q[3];
  assign misalign   = misalign_q;

endmodule

// File: tb/tb_gpio_lsb_merge.sv
// Directed bench for gpio_lsb_merge: delay, priming, lane enables, misalign and enable drop.
module tb_gpio_lsb_merge;
  import gpio_lsb_merge_pkg::*;

  logic        clock = 1'b0;
  logic        reset, enable, serial_strobe, dig_strobe, rx_strobe;
  logic        rx_dig0_i, rx_dig0_q, rx_dig1_i, rx_dig1_q;
  logic [6:0]  serial_addr;
  logic [31:0] serial_data;
  logic [15:0] ch0_i, ch0_q, ch1_i, ch1_q;
  logic        out_strobe, misalign;
  logic [15:0] out0_i, out0_q, out1_i, out1_q;

  int n_chk  = 0;
  int n_fail = 0;

  gpio_lsb_merge dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .serial_addr   (serial_addr),
    .serial_data   (serial_data),
    .serial_strobe (serial_strobe),
    .dig_strobe    (dig_strobe),
    .rx_dig0_i     (rx_dig0_i),
    .rx_dig0_q     (rx_dig0_q),
    .rx_dig1_i     (rx_dig1_i),
    .rx_dig1_q     (rx_dig1_q),
    .rx_strobe     (rx_strobe),
    .ch0_i         (ch0_i),
    .ch0_q         (ch0_q),
    .ch1_i         (ch1_i),
    .ch1_q         (ch1_q),
    .out_strobe    (out_strobe),
    .out0_i        (out0_i),
    .out0_q        (out0_q),
    .out1_i        (out1_i),
    .out1_q        (out1_q),
    .misalign      (misalign)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] v);
    serial_addr   = FR_RX_GPIO_MERGE;
    serial_data   = v;
    serial_strobe = 1'b1;
    tick();
    serial_strobe = 1'b0;
    serial_data   = '0;
  endtask

  // mode 0: dig then rx next cycle; 1: dig_valid and rx in the same cycle; 2: no rx
  task automatic sample(input logic [3:0] b, input int mode);
    dig_strobe = 1'b1;
    tick();
    dig_strobe = 1'b0;
    {rx_dig1_q, rx_dig1_i, rx_dig0_q, rx_dig0_i} = b;
    if (mode == 1) rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
    if (mode == 0) begin
      rx_strobe = 1'b1;
      tick();
      rx_strobe = 1'b0;
    end
    if (mode == 2) tick();
  endtask

  task automatic expect_out(input string tag, input logic [15:0] e0i, input logic [15:0] e0q,
                            input logic [15:0] e1i, input logic [15:0] e1q);
    chk({tag, " strobe"}, {31'b0, out_strobe}, 32'd1);
    chk({tag, " out0_i"}, {16'b0, out0_i}, {16'b0, e0i});
    chk({tag, " out0_q"}, {16'b0, out0_q}, {16'b0, e0q});
    chk({tag, " out1_i"}, {16'b0, out1_i}, {16'b0, e1i});
    chk({tag, " out1_q"}, {16'b0, out1_q}, {16'b0, e1q});
  endtask

  task automatic set_base();
    ch0_i = 16'h1234; ch0_q = 16'h5678; ch1_i = 16'h9abc; ch1_q = 16'hdef0;
  endtask

  logic [3:0] pat [20];
  logic [3:0] e;

  initial begin
    reset = 1'b1; enable = 1'b0; serial_strobe = 1'b0; dig_strobe = 1'b0; rx_strobe = 1'b0;
    {rx_dig1_q, rx_dig1_i, rx_dig0_q, rx_dig0_i} = 4'b0;
    serial_addr = '0; serial_data = '0;
    set_base();
    tick(); tick();
    chk("rst out_strobe", {31'b0, out_strobe}, 32'd0);
    chk("rst misalign",   {31'b0, misalign},   32'd0);
    chk("rst out0_i",     {16'b0, out0_i},     32'd0);
    chk("rst out1_q",     {16'b0, out1_q},     32'd0);
    reset = 1'b0;
    tick();

    // D=0, both channels
    wr_reg(32'h003);
    enable = 1'b1;
    tick();
    sample(4'b1111, 0); expect_out("d0 s0", 16'h1235, 16'h5679, 16'h9abd, 16'hdef1);
    sample(4'b0000, 0); expect_out("d0 s1", 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    sample(4'b0101, 0); expect_out("d0 s2", 16'h1235, 16'h5678, 16'h9abd, 16'hdef0);
    sample(4'b1010, 0); expect_out("d0 s3", 16'h1234, 16'h5679, 16'h9abc, 16'hdef1);
    // same-cycle write/read returns the previous entry (1010)
    sample(4'b0101, 1); expect_out("simul", 16'h1234, 16'h5679, 16'h9abc, 16'hdef1);
    sample(4'b0000, 0); expect_out("after simul", 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    chk("d0 misalign", {31'b0, misalign}, 32'd0);

    // D=3: three primed outputs then bits delayed by three samples
    wr_reg(32'h303);
    sample(4'b1111, 0); expect_out("d3 s0", 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    sample(4'b0000, 0); expect_out("d3 s1", 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    sample(4'b0000, 0); expect_out("d3 s2", 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    sample(4'b0101, 0); expect_out("d3 s3", 16'h1235, 16'h5679, 16'h9abd, 16'hdef1);
    sample(4'b1111, 0); expect_out("d3 s4", 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    sample(4'b1111, 0); expect_out("d3 s5", 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    sample(4'b0000, 0); expect_out("d3 s6", 16'h1235, 16'h5678, 16'h9abd, 16'hdef0);

    // D=15 over 20 samples: pointer wraps past the 16-entry line
    wr_reg(32'hF03);
    for (int k = 0; k < 20; k++) pat[k] = 4'(k * 7 + 3);
    for (int k = 0; k < 20; k++) begin
      sample(pat[k], 0);
      e = (k < 15) ? 4'b0000 : pat[k-15];
      expect_out($sformatf("d15 s%0d", k), 16'h1234 | {15'b0, e[0]}, 16'h5678 | {15'b0, e[1]},
                 16'h9abc | {15'b0, e[2]}, 16'hdef0 | {15'b0, e[3]});
    end
    chk("d15 misalign", {31'b0, misalign}, 32'd0);

    // skipped rx_strobe in RUN
    sample(4'b0000, 2);
    sample(4'b0000, 0);
    chk("misalign set",    {31'b0, misalign}, 32'd1);
    sample(4'b0000, 0);
    chk("misalign sticky", {31'b0, misalign}, 32'd1);
    wr_reg(32'h203);
    chk("misalign clr",    {31'b0, misalign}, 32'd0);
    sample(4'b1111, 0); expect_out("reprime", 16'h1234, 16'h5678, 16'h9abc, 16'hdef0);
    chk("prime misalign",  {31'b0, misalign}, 32'd0);

    // ch0 only; ch1 passes through untouched
    enable = 1'b0;
    tick();
    wr_reg(32'h001);
    enable = 1'b1;
    tick();
    ch1_i = 16'h9abd; ch1_q = 16'hdef1;
    sample(4'b0011, 0); expect_out("ch1 off a", 16'h1235, 16'h5679, 16'h9abd, 16'hdef1);
    ch1_i = 16'h1111; ch1_q = 16'h2222;
    sample(4'b1100, 0); expect_out("ch1 off b", 16'h1234, 16'h5678, 16'h1111, 16'h2222);
    // I-only: Q lanes pass through
    wr_reg(32'h005);
    ch0_q = 16'h5679;
    sample(4'b0001, 0); expect_out("ionly", 16'h1235, 16'h5679, 16'h1111, 16'h2222);

    // enable drop: IDLE, no out_strobe, data passes unchanged
    enable = 1'b0;
    tick();
    ch0_i = 16'h4321;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
    chk("idle out_strobe", {31'b0, out_strobe}, 32'd0);
    chk("idle out0_i",     {16'b0, out0_i},     32'h4321);
    chk("idle misalign",   {31'b0, misalign},   32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
